// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD block: ALU mode codes, controller state
// encoding, the controller's flag bundle and the default iteration limit.
package gcd_pkg;

  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_CMP  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MOD  = 3'd3;
  localparam logic [2:0] ALU_PASS = 3'd4;

  // 16-bit Euclid needs at most 23 modulo steps, so 24 is a safe abort point.
  localparam int MAX_ITER_DEFAULT = 24;
  localparam int ITER_W_DEFAULT   = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SORT  = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_MOD   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  typedef struct packed {
    logic [2:0] alu_mode;
    logic       wren_zw_gross;
    logic       wren_zw_klein;
    logic       wren_zw_in_zahlen;
    logic       wren_erg_modulo;
    logic       wren_to_new_numbers;
    logic       zahl1_to_alu_a;
    logic       zahl2_to_alu_b;
    logic       erg_modulo_to_alu_a;
    logic       check_for_termination;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Moore flag table: the flags a state shows while the FSM sits in it.
  function automatic ctrl_t state_flags(input state_t s);
    ctrl_t c;
    c          = '0;
    c.alu_mode = ALU_NOP;
    c.busy     = (s != S_IDLE);
    case (s)
      S_SORT: begin
        c.alu_mode       = ALU_CMP;
        c.zahl1_to_alu_a = 1'b1;
        c.zahl2_to_alu_b = 1'b1;
        c.wren_zw_gross  = 1'b1;
        c.wren_zw_klein  = 1'b1;
      end
      S_LOAD:  c.wren_zw_in_zahlen     = 1'b1;
      S_CHECK: c.check_for_termination = 1'b1;
      S_MOD: begin
        c.alu_mode        = ALU_MOD;
        c.wren_erg_modulo = 1'b1;
      end
      S_SHIFT: begin
        c.wren_to_new_numbers = 1'b1;
        c.erg_modulo_to_alu_a = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      S_ERR:   c.done = 1'b1;
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gcd_controller.sv
// Control FSM for the Euclid-by-modulo GCD datapath. Optional output
// iter_cnt_o is present when GCD_CTRL_ITER_COUNT_EN is defined.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEFAULT,
  parameter int ITER_W   = ITER_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              b_zero_i,
  input  logic              a_zero_i,
  output logic [2:0]        alu_mode_o,
  output logic              wren_zw_gross_o,
  output logic              wren_zw_klein_o,
  output logic              wren_zw_in_zahlen_o,
  output logic              wren_erg_modulo_o,
  output logic              wren_to_new_numbers_o,
  output logic              zahl1_to_alu_a_o,
  output logic              zahl2_to_alu_b_o,
  output logic              erg_modulo_to_alu_a_o,
  output logic              check_for_termination_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef GCD_CTRL_ITER_COUNT_EN
  ,
  output logic [ITER_W-1:0] iter_cnt_o
`endif
);

  state_t            state_q, state_nxt;
  ctrl_t             ctrl_q;
  logic [ITER_W-1:0] cnt_q, cnt_nxt, cnt_inc;
  logic              err_q, err_nxt;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_SORT;
          cnt_nxt   = '0;
        end
      end
      S_SORT:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (a_zero_i && b_zero_i) state_nxt = S_ERR;
        else if (b_zero_i)        state_nxt = S_DONE;
        else                      state_nxt = S_MOD;
      end
      S_MOD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        cnt_nxt   = cnt_inc;
        state_nxt = (cnt_inc == ITER_W'(MAX_ITER)) ? S_ERR : S_CHECK;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // err is sticky across IDLE and only a fresh start clears it.
  always_comb begin
    err_nxt = err_q;
    if (state_nxt == S_ERR)             err_nxt = 1'b1;
    else if (state_q == S_IDLE && start_i) err_nxt = 1'b0;
  end

  // Flags are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= state_flags(S_IDLE);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= state_flags(state_nxt);
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

`ifdef GCD_CTRL_ITER_COUNT_EN
  logic [ITER_W-1:0] iter_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_out_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      iter_out_q <= '0;
    end else if (state_nxt == S_DONE || state_nxt == S_ERR) begin
      iter_out_q <= cnt_nxt;
    end
  end

  assign iter_cnt_o = iter_out_q;
`endif

  assign alu_mode_o              = ctrl_q.alu_mode;
  assign wren_zw_gross_o         = ctrl_q.wren_zw_gross;
  assign wren_zw_klein_o         = ctrl_q.wren_zw_klein;
  assign wren_zw_in_zahlen_o     = ctrl_q.wren_zw_in_zahlen;
  assign wren_erg_modulo_o       = ctrl_q.wren_erg_modulo;
  assign wren_to_new_numbers_o   = ctrl_q.wren_to_new_numbers;
  assign zahl1_to_alu_a_o        = ctrl_q.zahl1_to_alu_a;
  assign zahl2_to_alu_b_o        = ctrl_q.zahl2_to_alu_b;
  assign erg_modulo_to_alu_a_o   = ctrl_q.erg_modulo_to_alu_a;
  assign check_for_termination_o = ctrl_q.check_for_termination;
  assign busy_o                  = ctrl_q.busy;
  assign done_o                  = ctrl_q.done;
  assign err_o                   = err_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a small datapath model closes the loop, and an
// arithmetic Euclid reference predicts the per-cycle flag trace and result.
module tb_gcd_controller;

  localparam int MAX_ITER = 24;
  localparam int ITER_W   = 5;

  localparam int P_IDLE  = 0;
  localparam int P_SORT  = 1;
  localparam int P_LOAD  = 2;
  localparam int P_CHECK = 3;
  localparam int P_MOD   = 4;
  localparam int P_SHIFT = 5;
  localparam int P_DONE  = 6;
  localparam int P_ERR   = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       b_zero, a_zero;
  logic [2:0] alu_mode;
  logic       wren_gross, wren_klein, wren_in_zahlen, wren_erg_mod, wren_new_nums;
  logic       z1_a, z2_b, erg_a, check_term, busy, done, err;
`ifdef GCD_CTRL_ITER_COUNT_EN
  logic [ITER_W-1:0] iter_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [14:0] exp_q[$];
  logic        exp_err = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gcd_controller #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_i                 (start),
    .b_zero_i                (b_zero),
    .a_zero_i                (a_zero),
    .alu_mode_o              (alu_mode),
    .wren_zw_gross_o         (wren_gross),
    .wren_zw_klein_o         (wren_klein),
    .wren_zw_in_zahlen_o     (wren_in_zahlen),
    .wren_erg_modulo_o       (wren_erg_mod),
    .wren_to_new_numbers_o   (wren_new_nums),
    .zahl1_to_alu_a_o        (z1_a),
    .zahl2_to_alu_b_o        (z2_b),
    .erg_modulo_to_alu_a_o   (erg_a),
    .check_for_termination_o (check_term),
    .busy_o                  (busy),
    .done_o                  (done),
    .err_o                   (err)
`ifdef GCD_CTRL_ITER_COUNT_EN
    ,
    .iter_cnt_o              (iter_cnt)
`endif
  );

  // ---------------- datapath model driven by the controller flags ----------------
  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] zw_g = '0, zw_k = '0, dp_a = '0, dp_b = '0, dp_erg = '0;
  logic        force_nz = 1'b0;

  always @(posedge clk) begin
    if (wren_gross)     zw_g <= (op_a > op_b) ? op_a : op_b;
    if (wren_klein)     zw_k <= (op_a > op_b) ? op_b : op_a;
    if (wren_in_zahlen) begin dp_a <= zw_g; dp_b <= zw_k; end
    if (wren_erg_mod)   dp_erg <= (dp_b == 16'd0) ? 16'd0 : dp_a % dp_b;
    if (wren_new_nums)  begin dp_a <= dp_b; dp_b <= dp_erg; end
  end

  assign b_zero = force_nz ? 1'b0 : (dp_b == 16'd0);
  assign a_zero = (dp_a == 16'd0);

  logic [14:0] act_vec;
  assign act_vec = {alu_mode, wren_gross, wren_klein, wren_in_zahlen, wren_erg_mod,
                    wren_new_nums, z1_a, z2_b, erg_a, check_term, busy, done, err};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t actual=%0h expected=%0h", tag, $time, act, expv);
    end
  endtask

  // Expected outputs for each phase of a run, straight from the flag table.
  function automatic logic [14:0] vec_of(input int p, input logic e);
    logic [2:0] alu;
    logic g, k, inz, em, nn, za, zb, ea, ck, bs, dn;
    alu = 3'd0;
    {g, k, inz, em, nn, za, zb, ea, ck, dn} = '0;
    bs = (p != P_IDLE);
    case (p)
      P_SORT:  begin alu = 3'd1; g = 1; k = 1; za = 1; zb = 1; end
      P_LOAD:  inz = 1;
      P_CHECK: ck = 1;
      P_MOD:   begin alu = 3'd3; em = 1; end
      P_SHIFT: begin nn = 1; ea = 1; end
      P_DONE:  dn = 1;
      P_ERR:   dn = 1;
      default: ;
    endcase
    return {alu, g, k, inz, em, nn, za, zb, ea, ck, bs, dn, e};
  endfunction

  // ---------------- reference model ----------------
  task automatic build_trace(input logic [15:0] a, input logic [15:0] b, input logic fnz,
                             output int k, output logic e, output logic [15:0] res);
    logic [15:0] x, y, t;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    k = 0;
    while (y != 0) begin
      t = x % y; x = y; y = t; k++;
    end
    res = x;
    if (fnz) k = MAX_ITER;
    exp_q.push_back(vec_of(P_SORT, 1'b0));
    exp_q.push_back(vec_of(P_LOAD, 1'b0));
    if (a == 0 && b == 0 && !fnz) begin
      e = 1'b1;
      k = 0;
      exp_q.push_back(vec_of(P_CHECK, 1'b0));
      exp_q.push_back(vec_of(P_ERR, 1'b1));
    end else begin
      e = (k >= MAX_ITER);
      for (int i = 0; i < ((k >= MAX_ITER) ? MAX_ITER : k); i++) begin
        exp_q.push_back(vec_of(P_CHECK, 1'b0));
        exp_q.push_back(vec_of(P_MOD, 1'b0));
        exp_q.push_back(vec_of(P_SHIFT, 1'b0));
      end
      if (e) begin
        k = MAX_ITER;
        exp_q.push_back(vec_of(P_ERR, 1'b1));
      end else begin
        exp_q.push_back(vec_of(P_CHECK, 1'b0));
        exp_q.push_back(vec_of(P_DONE, 1'b0));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_gcd(input logic [15:0] a, input logic [15:0] b, input logic fnz,
                         input logic hold);
    int          k, len, cyc, done_at;
    logic        e;
    logic [15:0] res;
    logic [4:0]  wr;
    build_trace(a, b, fnz, k, e, res);
    len      = exp_q.size();
    op_a     = a;
    op_b     = b;
    force_nz = fnz;
    start    = 1'b1;
    done_at  = -1;
    cyc      = 0;
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      cyc++;
      if (!hold) start = 1'b0;
      check("trace", 32'(act_vec), 32'(exp_q.pop_front()));
      wr = {wren_gross, wren_klein, wren_in_zahlen, wren_erg_mod, wren_new_nums};
      check("wren_1hot", 32'(($countones(wr) <= 1) || (wr == 5'b11000)), 32'd1);
      if (done && done_at < 0) begin
        done_at = cyc;
        if (!e) check("result", 32'(dp_a), 32'(res));
      end
      if (exp_q.size() > 0) begin @(posedge clk); #1; end
    end
    check("done_cycle", 32'(done_at), 32'(len));
    exp_err = e;
    @(posedge clk); #1;
    check("idle_after", 32'(act_vec), 32'(vec_of(P_IDLE, exp_err)));
`ifdef GCD_CTRL_ITER_COUNT_EN
    check("iter_cnt", 32'(iter_cnt), 32'(k));
`endif
    force_nz = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(act_vec), 32'(vec_of(P_IDLE, 1'b0)));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_no_start", 32'(act_vec), 32'(vec_of(P_IDLE, 1'b0)));

    run_gcd(16'd48, 16'd18, 1'b0, 1'b0);
    run_gcd(16'd7, 16'd0, 1'b0, 1'b0);
    run_gcd(16'd0, 16'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("err_sticky", 32'(act_vec), 32'(vec_of(P_IDLE, 1'b1)));
    end
    run_gcd(16'd0, 16'd7, 1'b0, 1'b0);
    run_gcd(16'd46368, 16'd28657, 1'b0, 1'b0);
    run_gcd(16'd48, 16'd18, 1'b1, 1'b0);

    // start held across a whole run, then a back-to-back restart
    run_gcd(16'd30, 16'd12, 1'b0, 1'b1);
    run_gcd(16'd100, 16'd75, 1'b0, 1'b0);

    // reset while in MOD
    op_a  = 16'd48;
    op_b  = 16'd18;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_mod", 32'(act_vec), 32'(vec_of(P_MOD, 1'b0)));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset", 32'(act_vec), 32'(vec_of(P_IDLE, 1'b0)));
`ifdef GCD_CTRL_ITER_COUNT_EN
    check("mid_reset_cnt", 32'(iter_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_reset_idle", 32'(act_vec), 32'(vec_of(P_IDLE, 1'b0)));
    end
    exp_err = 1'b0;

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 16'($urandom_range(0, 5));
        rb = 16'($urandom_range(0, 5));
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      run_gcd(ra, rb, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("gap_idle", 32'(act_vec), 32'(vec_of(P_IDLE, exp_err)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL timeout @%0t actual=running expected=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM driving the GCD datapath (Euclid by repeated modulo).
- Accepts a start request and sequences the datapath's ALU-mode, write-back and register-transfer flags until the divisor is zero.
- Reports done/busy/error upstream.
- Sits beside the datapath in the top level: its outputs drive the datapath's control inputs, and the datapath's status flags return here.

Parameters:
- MAX_ITER, 24, modulo iterations before abort (Euclid on 16-bit operands needs at most 23).
- ITER_W, 5, width of the iteration counter (must satisfy 2**ITER_W > MAX_ITER).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  request a GCD run; sampled only in IDLE.
- b_zero_i  in  1  datapath status: current divisor register == 0.
- a_zero_i  in  1  datapath status: current dividend register == 0.
- alu_mode_o  out  3  ALU operation select.
- wren_zw_gross_o / wren_zw_klein_o  out  1 each  write larger/smaller sorted operand.
- wren_zw_in_zahlen_o  out  1  copy sorted operands into working registers.
- wren_erg_modulo_o  out  1  latch modulo result.
- wren_to_new_numbers_o  out  1  shift: a<=b, b<=erg_modulo.
- zahl1_to_alu_a_o, zahl2_to_alu_b_o, erg_modulo_to_alu_a_o  out  1 each  operand routing.
- check_for_termination_o  out  1  datapath evaluates zero flags this cycle.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse; result valid in datapath.
- err_o  out  1  sticky until next start: iteration limit hit, or both operands zero.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; alu_mode_o = ALU_NOP.
  - Iteration counter 0.
  - Reset asserted mid-run aborts immediately; no done_o pulse.
- States: IDLE, SORT, LOAD, CHECK, MOD, SHIFT, DONE, ERR.
- Outputs are Moore and registered, so each state's flags are visible in the cycle the FSM occupies that state.
- IDLE:
  - busy_o = 0.
  - start_i = 1 → SORT; clear err_o and the counter.
- SORT:
  - alu_mode_o = ALU_CMP; zahl1_to_alu_a_o = zahl2_to_alu_b_o = 1.
  - wren_zw_gross_o = wren_zw_klein_o = 1.
  - → LOAD.
- LOAD: wren_zw_in_zahlen_o = 1 → CHECK.
- CHECK:
  - check_for_termination_o = 1.
  - a_zero_i & b_zero_i → ERR.
  - b_zero_i → DONE.
  - Otherwise → MOD.
- MOD:
  - alu_mode_o = ALU_MOD; wren_erg_modulo_o = 1.
  - → SHIFT.
- SHIFT:
  - wren_to_new_numbers_o = 1; erg_modulo_to_alu_a_o = 1.
  - Counter increments.
  - If the counter reaches MAX_ITER after incrementing → ERR; else → CHECK.
- DONE: done_o = 1 for exactly one cycle → IDLE.
- ERR:
  - err_o = 1 (held until next start); done_o = 1 for one cycle.
  - → IDLE.
- busy_o = 1 in every state except IDLE.
- start_i while busy_o = 1 is ignored, not queued.
- Latency: 3 + 3·k + 1 cycles from start to done_o, where k = number of modulo iterations.
  - k = 0 (divisor already 0): done_o in the 4th cycle after start.
- Only one wren_* flag is asserted per cycle, except the gross/klein pair in SORT.
- Operand-routing flags are 0 in any state not listed above.

Optional Feature:
- Macro GCD_CTRL_ITER_COUNT_EN.
- Defined: extra output iter_cnt_o [ITER_W-1:0], holding the final iteration count from DONE/ERR until the next start; reset 0.
- Undefined: port absent; the counter is used internally only for the MAX_ITER abort.

Decomposition:
- Package gcd_pkg holds:
  - ALU mode constants: ALU_NOP=3'd0, ALU_CMP=3'd1, ALU_SUB=3'd2, ALU_MOD=3'd3, ALU_PASS=3'd4.
  - FSM state encoding.
  - Default MAX_ITER.
  - Shared by datapath, alu and controller.
- No sub-module. The iteration counter is a few lines in the same always block; splitting it out adds nothing.

Test Plan:
- Reset mid-run: rst=1 during MOD → next cycle IDLE, all outputs 0, no done_o.
- Normal run, a=48, b=18, paired with datapath model:
  - Iterations 48%18=12, 18%12=6, 12%6=0, so k=3.
  - done_o pulses at cycle 13 after start; result 6; err_o=0.
- Divisor zero, a=7, b=0:
  - CHECK sees b_zero_i → done_o at cycle 4.
  - No wren_erg_modulo_o pulse; err_o=0.
- Both zero, a=0, b=0: → ERR; err_o=1 and done_o pulses once; a new start clears err_o.
- Timeout: force b_zero_i=0 permanently, MAX_ITER=24 → ERR after 24 SHIFT cycles; err_o=1; iter_cnt_o=24 with the macro defined.
- start_i held high throughout a run → exactly one run, then an immediate restart from IDLE; flag one-hot check (except SORT pair) asserted every cycle.
